// File: rtl/mintz80_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mintz80_pkg
// Description : MinZ80 I/O port map and tone state encoding shared by the
//               CPLD peripherals.
// Revision    : 1.0 - initial release
// ============================================================================
package mintz80_pkg;

    localparam logic [7:0] IO_WIN_BASE   = 8'hD0;
    localparam logic [7:0] TONE_PER_PORT = IO_WIN_BASE | 8'h02;
    localparam logic [7:0] TONE_DUR_PORT = IO_WIN_BASE | 8'h03;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_TONE = 1'b1
    } tone_state_e;

    // $D2 and $D3 differ only in A0, so the pair shares one decode.
    function automatic logic is_tone_port(input logic [7:0] addr);
        return addr[7:1] == TONE_PER_PORT[7:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/beep_tone_if.sv
`default_nettype none
// ============================================================================
// Module      : beep_tone_if
// Description : Z80 I/O control and address signals seen by the tone block.
// Revision    : 1.0 - initial release
// ============================================================================
interface beep_tone_if;

    logic       iorq;
    logic       rd;
    logic       wr;
    logic [7:0] a07;

    modport master (
        output iorq,
        output rd,
        output wr,
        output a07
    );

    modport slave (
        input iorq,
        input rd,
        input wr,
        input a07
    );

endinterface
`default_nettype wire

// File: rtl/io_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module      : io_strobe_sync
// Description : Two-flop synchronizer plus rising-edge detect; turns an
//               asynchronous bus strobe into a single-clk pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module io_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_strobe,
    output logic o_pulse
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       prev_q;
    logic       prev_d;

    always_comb begin
        sync_d = {sync_q[0], i_strobe};
        prev_d = sync_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_pulse = sync_q[1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/beep_tone.sv
`default_nettype none
// ============================================================================
// Module      : beep_tone
// Description : Programmable square-wave tone generator on Z80 ports $D2/$D3.
// Revision    : 1.0 - initial release
// ============================================================================
module beep_tone
    import mintz80_pkg::*;
#(
    parameter int PRESCALE = 64,
    parameter int DUR_TICK = 16384
) (
    input  logic              clk,
    input  logic              reset,
    beep_tone_if.slave        bus,
    inout  wire  [7:0]        data,
    output logic              spk,
    output logic              busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DUR_TICK > 1) ? $clog2(DUR_TICK) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] TICK_LAST = DW'(DUR_TICK - 1);

    tone_state_e   state_q;
    tone_state_e   state_d;
    logic [7:0]    period_q;
    logic [7:0]    period_d;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic [7:0]    hp_q;
    logic [7:0]    hp_d;
    logic [DW-1:0] tick_q;
    logic [DW-1:0] tick_d;
    logic [7:0]    dur_q;
    logic [7:0]    dur_d;
    logic          spk_q;
    logic          spk_d;

    logic          ws;
    logic          wp;
    logic          rd_en;
    logic [7:0]    rd_val;

    assign ws = !bus.iorq && !bus.wr && is_tone_port(bus.a07);

    io_strobe_sync u_sync (
        .clk      (clk),
        .rst_n    (reset),
        .i_strobe (ws),
        .o_pulse  (wp)
    );

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        pre_d    = pre_q;
        hp_d     = hp_q;
        tick_d   = tick_q;
        dur_d    = dur_q;
        spk_d    = spk_q;

        if (state_q == ST_TONE) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
            if (pre_q == PRE_LAST) begin
                // >= rather than == so a period shrunk below hp_q still toggles
                if (hp_q >= period_q) begin
                    hp_d  = 8'd0;
                    spk_d = ~spk_q;
                end else begin
                    hp_d = hp_q + 8'd1;
                end
            end
            if (period_q == 8'd0) begin
                spk_d = 1'b0;
            end

            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + DW'(1);
            if (tick_q == TICK_LAST && dur_q != 8'd0) begin
                dur_d = dur_q - 8'd1;
                if (dur_q == 8'd1) begin
                    state_d = ST_IDLE;
                    spk_d   = 1'b0;
                    pre_d   = '0;
                    hp_d    = 8'd0;
                    tick_d  = '0;
                end
            end
        end

        // Bus writes override the running tone logic in the same cycle.
        if (wp) begin
            if (!bus.a07[0]) begin
                period_d = data;
            end else begin
                dur_d   = data;
                pre_d   = '0;
                hp_d    = 8'd0;
                tick_d  = '0;
                spk_d   = 1'b0;
                state_d = (data != 8'd0) ? ST_TONE : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            period_q <= 8'd0;
            pre_q    <= '0;
            hp_q     <= 8'd0;
            tick_q   <= '0;
            dur_q    <= 8'd0;
            spk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            pre_q    <= pre_d;
            hp_q     <= hp_d;
            tick_q   <= tick_d;
            dur_q    <= dur_d;
            spk_q    <= spk_d;
        end
    end

    assign spk  = spk_q;
    assign busy = (state_q == ST_TONE);

    // Gating on WR# high keeps the block off the bus during any write cycle.
    always_comb begin
        rd_en  = 1'b0;
        rd_val = 8'h00;
        if (!bus.iorq && !bus.rd && bus.wr) begin
            if (bus.a07 == TONE_PER_PORT) begin
                rd_en  = 1'b1;
                rd_val = period_q;
            end else if (bus.a07 == TONE_DUR_PORT) begin
                rd_en  = 1'b1;
                rd_val = {7'b0, busy};
            end
        end
    end

    assign data = rd_en ? rd_val : 8'bz;

endmodule
`default_nettype wire

// File: tb/tb_beep_tone.sv
`default_nettype none
// ============================================================================
// Module      : tb_beep_tone
// Description : Scoreboard bench for beep_tone with PRESCALE=4, DUR_TICK=64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beep_tone;

    typedef struct {
        int  cyc;
        bit  is_spk;
        bit  val;
    } ev_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_t;

    logic       clk;
    logic       reset = 1'b0;
    logic       spk;
    logic       busy;
    wire  [7:0] data;
    logic [7:0] tb_dout = 8'h00;
    logic       tb_oe   = 1'b0;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  evq[$];
    rd_t  rdq[$];
    event rd_ev;

    beep_tone_if bus_if ();

    assign data = tb_oe ? tb_dout : 8'bz;
    pullup pu_data (data);

    beep_tone #(
        .PRESCALE (4),
        .DUR_TICK (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .data  (data),
        .spk   (spk),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ scoreboard
    function automatic void push_ev(input int c, input bit s, input bit v);
        ev_t e;
        e.cyc = c; e.is_spk = s; e.val = v;
        evq.push_back(e);
    endfunction

    // Expected busy/spk edges of one tone segment; spk starts low.
    function automatic void push_tone(input int rise, input int first, input int half,
                                      input int stop, input bit fall);
        bit s = 1'b0;
        if (rise >= 0) push_ev(rise, 1'b0, 1'b1);
        if (half > 0) begin
            for (int t = first; t < stop; t += half) begin
                s = ~s;
                push_ev(t, 1'b1, s);
            end
        end
        if (fall) push_ev(stop, 1'b0, 1'b0);
        if (s) push_ev(stop, 1'b1, 1'b0);
    endfunction

    task automatic check_event(input bit is_spk, input logic v);
        ev_t e;
        checks++;
        if (evq.size() == 0) begin
            errors++;
            $display("FAIL event: %s went %0b at cyc %0d, no edge required",
                     is_spk ? "spk" : "busy", v, cyc);
        end else begin
            e = evq.pop_front();
            if (e.cyc != cyc || e.is_spk != is_spk || e.val != v) begin
                errors++;
                $display("FAIL event: got %s=%0b at cyc %0d, required %s=%0b at cyc %0d",
                         is_spk ? "spk" : "busy", v, cyc,
                         e.is_spk ? "spk" : "busy", e.val, e.cyc);
            end
        end
    endtask

    initial begin : edge_monitor
        logic busy_prev;
        logic spk_prev;
        busy_prev = 1'b0;
        spk_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (busy !== busy_prev) begin
                check_event(1'b0, busy);
                busy_prev = busy;
            end
            if (spk !== spk_prev) begin
                check_event(1'b1, spk);
                spk_prev = spk;
            end
        end
    end

    initial begin : read_monitor
        rd_t r;
        forever begin
            @(rd_ev);
            if (rdq.size() != 0) begin
                r = rdq.pop_front();
                checks++;
                if (data !== r.exp) begin
                    errors++;
                    $display("FAIL read $%h: data=%h, required %h", r.addr, data, r.exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // --------------------------------------------------------------- stimulus
    // All bus tasks start and end at a falling clk edge; a write acts at cyc+3.
    task automatic do_write(input logic [7:0] a, input logic [7:0] v);
        bus_if.a07  = a;
        tb_dout     = v;
        tb_oe       = 1'b1;
        bus_if.iorq = 1'b0;
        bus_if.wr   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus_if.iorq = 1'b1;
        bus_if.wr   = 1'b1;
        tb_oe       = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input bit with_wr);
        rd_t r;
        bus_if.a07  = a;
        bus_if.iorq = 1'b0;
        bus_if.rd   = 1'b0;
        if (with_wr) bus_if.wr = 1'b0;
        #1;
        r.addr = a; r.exp = exp;
        rdq.push_back(r);
        -> rd_ev;
        #1;
        bus_if.iorq = 1'b1;
        bus_if.rd   = 1'b1;
        bus_if.wr   = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin : stim
        int s;
        int s1;
        bus_if.iorq = 1'b1;
        bus_if.rd   = 1'b1;
        bus_if.wr   = 1'b1;
        bus_if.a07  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        check("reset busy", {7'b0, busy}, 8'h00);
        check("reset spk", {7'b0, spk}, 8'h00);
        do_read(8'hD2, 8'h00, 1'b0);
        do_read(8'hD3, 8'h00, 1'b0);

        // Period 3, duration 2: half period 16 clk, 128 clk long
        do_write(8'hD2, 8'd3);
        s = cyc + 3;
        push_tone(s, s + 16, 16, s + 128, 1'b1);
        do_write(8'hD3, 8'd2);
        wait_until(s + 132);
        check("t1 end busy", {7'b0, busy}, 8'h00);
        check("t1 end spk", {7'b0, spk}, 8'h00);

        // Period 0: silent rest of 64 clk
        do_write(8'hD2, 8'd0);
        s = cyc + 3;
        push_tone(s, 0, 0, s + 64, 1'b1);
        do_write(8'hD3, 8'd1);
        wait_until(s + 30);
        check("rest busy", {7'b0, busy}, 8'h01);
        check("rest spk", {7'b0, spk}, 8'h00);
        wait_until(s + 68);

        // Restart 90 clk into a 5-unit tone with a 1-unit tone
        do_write(8'hD2, 8'd3);
        s1 = cyc + 3;
        push_tone(s1, s1 + 16, 16, s1 + 90, 1'b0);
        push_tone(-1, s1 + 106, 16, s1 + 154, 1'b1);
        do_write(8'hD3, 8'd5);
        wait_until(s1 + 87);
        do_write(8'hD3, 8'd1);
        wait_until(s1 + 160);

        // Period shrunk 10 -> 2 after hp_cnt reached 6; then stop write
        do_write(8'hD2, 8'd10);
        s = cyc + 3;
        push_tone(s, s + 28, 12, s + 100, 1'b1);
        do_write(8'hD3, 8'd20);
        wait_until(s + 23);
        do_write(8'hD2, 8'd2);
        wait_until(s + 97);
        do_write(8'hD3, 8'd0);
        wait_until(s + 104);
        check("stop busy", {7'b0, busy}, 8'h00);

        // Readback
        do_write(8'hD2, 8'hA5);
        do_read(8'hD2, 8'hA5, 1'b0);
        do_read(8'hD3, 8'h00, 1'b0);
        s = cyc + 3;
        push_tone(s, s + 664, 664, s + 64, 1'b1);
        do_write(8'hD3, 8'd1);
        wait_until(s + 10);
        do_read(8'hD3, 8'h01, 1'b0);
        wait_until(s + 70);
        do_read(8'hD3, 8'h00, 1'b0);
        do_read(8'hD4, 8'hFF, 1'b0);
        do_read(8'hD2, 8'hFF, 1'b1);

        // Asynchronous reset mid-tone while spk is high
        do_write(8'hD2, 8'd3);
        s = cyc + 3;
        push_tone(s, s + 16, 16, s + 21, 1'b1);
        do_write(8'hD3, 8'd3);
        wait_until(s + 20);
        #2 reset = 1'b0;
        #1;
        check("async rst busy", {7'b0, busy}, 8'h00);
        check("async rst spk", {7'b0, spk}, 8'h00);
        @(negedge clk);
        do_write(8'hD3, 8'd7);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (10) @(negedge clk);
        check("post rst busy", {7'b0, busy}, 8'h00);
        do_read(8'hD2, 8'h00, 1'b0);

        do_write(8'hD2, 8'd3);
        s = cyc + 3;
        push_tone(s, s + 16, 16, s + 64, 1'b1);
        do_write(8'hD3, 8'd1);
        wait_until(s + 70);

        repeat (5) @(negedge clk);
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL pending events: %0d edges never seen, required 0 (next at cyc %0d)",
                     evq.size(), evq[0].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/beep_tone.md
Name: beep_tone

Overview:
- Hardware tone generator on the MinZ80 CPLD. It sits on the same Z80 I/O decode as the MMU and drives the speaker pin alongside the bit-banged beep output; the board XORs the two.
- Software writes a tone period to I/O port $D2 and a duration to port $D3. The block then produces a square wave for the programmed time, with no further CPU involvement.
- It uses the free addresses $D2-$D3 inside the MMU's $D0-$DF window.
- It runs on the raw oscillator clk, not sysclk, so tone pitch is independent of the CPU clock divider.

Parameters:
- PRESCALE, 64, clk cycles per tone tick (at least 2).
- DUR_TICK, 16384, clk cycles per duration unit (at least 2).

Ports:
- clk  in  1  raw oscillator clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- iorq  in  1  Z80 IORQ#, active low, asynchronous to clk.
- rd  in  1  Z80 RD#, active low.
- wr  in  1  Z80 WR#, active low, asynchronous to clk.
- a07  in  8  Z80 A[7:0].
- data  inout  8  Z80 data bus; the block drives it only during reads of its own ports.
- spk  out  1  tone square wave.
- busy  out  1  high while a tone is running.

Behaviour:
- Reset values: period_r=0, state=IDLE, spk=0, busy=0, all counters 0, data=Z.
- Write strobe:
  - ws = !iorq && !wr && a07[7:1]==7'b1101001.
  - ws passes through a 2-flop synchronizer, then a rising-edge detect, giving a 1-clk pulse wp.
  - On the wp cycle, data[7:0] and a07[0] are captured.
  - Requirement on the bus: WR# must stay low for at least 3 clk periods. This holds for every clkdivide setting.
- Write $D2: period_r <= data. No other effect; a tone in progress adopts the new period at its next compare.
- Write $D3, data==0: go to IDLE at the next clk; spk=0; busy=0.
- Write $D3, data!=0: (re)start the tone.
  - dur_cnt <= data; prescale, half-period and duration-tick counters cleared; spk <= 0; state <= TONE.
  - This applies in both IDLE and TONE; a restart in TONE discards the remaining time.
- State machine:
  - IDLE to TONE on a start write.
  - TONE to IDLE when dur_cnt reaches 0, on a stop write, or on reset.
  - busy is exactly (state==TONE) and is a registered output.
- Tone generation in TONE:
  - The prescaler counts 0..PRESCALE-1 and wraps.
  - On each prescaler wrap: if hp_cnt >= period_r, toggle spk and clear hp_cnt; else hp_cnt++.
  - The >= compare handles a period shrunk mid-tone.
  - Half period = (period_r+1)*PRESCALE clk, so f = clk / (2*PRESCALE*(period_r+1)).
  - If period_r==0, spk is held 0 (silent rest) while the duration still runs.
- Duration:
  - The duration-tick counter counts 0..DUR_TICK-1.
  - On each wrap, dur_cnt decrements; when it reaches 0, state goes to IDLE and spk to 0 in the same clk.
  - If the start pulse wp is at clk edge T0, busy rises at T0+1 and falls at T0+1+dur*DUR_TICK.
- Read (combinational):
  - When !iorq && !rd: a07==$D2 drives period_r; a07==$D3 drives {7'b0,busy}; otherwise data=Z.
  - Must never drive during a write.
- Reset mid-tone: spk and busy drop asynchronously; no pending write survives.
- Counter widths:
  - Prescaler: clog2(PRESCALE).
  - hp_cnt: 8 bits, never exceeds 255.
  - Duration tick: clog2(DUR_TICK).
  - dur_cnt: 8 bits, no underflow, because it is only decremented when nonzero.

Decomposition:
- Shared package mintz80_pkg holds:
  - the port constants TONE_PER_PORT=8'hD2 and TONE_DUR_PORT=8'hD3;
  - the IO window base 8'hD0;
  - the state encoding: IDLE=0, TONE=1.
- One sub-module, io_strobe_sync: the 2-flop synchronizer plus rising-edge detect with asynchronous active-low reset. It is reusable for any bus strobe crossing into the clk domain.

Test Plan (PRESCALE=4, DUR_TICK=64):
- Out $D2,3 then out $D3,2 -> busy high 1 clk after wp; spk toggles every 16 clk (period 32 clk); busy and spk low exactly 128 clk after busy rose.
- Out $D2,0 then out $D3,1 -> busy high for 64 clk; spk stays 0 throughout.
- Out $D3,5, then at clk 100 out $D3,1 -> restart: spk=0 at the restart, busy falls 64 clk after the second wp; then out $D3,0 mid-tone -> idle next clk.
- Out $D2,10 during tone, after hp_cnt>=5, then out $D2,2 -> next prescale wrap toggles spk (>= rule); subsequent half period 12 clk.
- In $D2 after out $D2,8'hA5 -> data=8'hA5; in $D3 during tone -> 8'h01, after end -> 8'h00; in $D4 or any write -> data=Z.
- Assert reset mid-tone -> spk=0, busy=0 asynchronously; out $D3,1 after release -> normal 64-clk tone; WR# pulse of exactly 3 clk is captured once, never twice.
